// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetch requests, buffers the
// in-order responses in a small circular queue and presents them to the
// decoder. A redirect flushes the queue and marks every in-flight response
// as stale so that it is silently dropped when it arrives.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    // instruction memory request channel
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    // instruction memory response channel (in request order)
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    // branch/jump resolution
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    // decoder side
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    // architectural state
    logic [31:0]      r_fetch_pc;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_fill;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_alloc_cnt;
    logic [CNT_W-1:0] r_fill_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    // queue storage, left unreset so it maps onto plain distributed RAM
    logic [31:0] r_pc_mem    [DEPTH];
    logic [31:0] r_instr_mem [DEPTH];

    // derived control
    logic [CNT_W:0]   w_occupancy;
    logic [CNT_W-1:0] w_outstanding;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_rsp_drop;
    logic             w_rsp_fill;
    logic             w_rsp_accept;
    logic             w_out_valid;
    logic             w_deq;
    logic [CNT_W-1:0] w_redirect_drop;

    // Slots in use = queued entries plus stale responses still owed by memory.
    assign w_occupancy   = {1'b0, r_alloc_cnt} + {1'b0, r_drop_cnt};
    assign w_outstanding = r_alloc_cnt - r_fill_cnt;

    // Request is masked by reset directly so it is low while i_rst_n is low,
    // independent of the clock.
    assign w_req_valid = i_rst_n && !i_redirect_valid && (w_occupancy < DEPTH_OCC);
    assign w_req_fire  = w_req_valid && i_imem_req_ready;

    // Stale responses are consumed before any live one can be filled.
    assign w_rsp_drop   = i_imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_fill   = i_imem_rsp_valid && (r_drop_cnt == '0) && (r_alloc_cnt > r_fill_cnt);
    assign w_rsp_accept = w_rsp_drop || w_rsp_fill;

    // Only registered fill state feeds o_valid: no rsp -> o_valid path.
    assign w_out_valid = (r_fill_cnt != '0) && !i_redirect_valid;
    assign w_deq       = w_out_valid && i_ready;

    // Everything still owed by memory becomes stale, minus the response
    // that is being consumed in this very cycle.
    assign w_redirect_drop = r_drop_cnt + w_outstanding - CNT_W'(w_rsp_accept);

    assign o_imem_req_valid = w_req_valid;
    assign o_imem_req_addr  = r_fetch_pc;
    assign o_valid          = w_out_valid;
    assign o_pc             = r_pc_mem[r_head];
    assign o_instr          = r_instr_mem[r_head];

    // Fetch PC, pointers and counters; redirect overrides every other event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_pc  <= RESET_PC;
            r_head      <= '0;
            r_fill      <= '0;
            r_tail      <= '0;
            r_alloc_cnt <= '0;
            r_fill_cnt  <= '0;
            r_drop_cnt  <= '0;
        end else if (i_redirect_valid) begin
            r_fetch_pc  <= i_redirect_pc & 32'hFFFF_FFFC;
            r_head      <= '0;
            r_fill      <= '0;
            r_tail      <= '0;
            r_alloc_cnt <= '0;
            r_fill_cnt  <= '0;
            r_drop_cnt  <= w_redirect_drop;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_tail     <= r_tail + 1'b1;
            end
            if (w_rsp_fill) begin
                r_fill <= r_fill + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            r_alloc_cnt <= r_alloc_cnt + CNT_W'(w_req_fire) - CNT_W'(w_deq);
            r_fill_cnt  <= r_fill_cnt + CNT_W'(w_rsp_fill) - CNT_W'(w_deq);
            r_drop_cnt  <= r_drop_cnt - CNT_W'(w_rsp_drop);
        end
    end

    // Queue storage: PC written on request issue, instruction on response.
    always_ff @(posedge i_clk) begin
        if (w_req_fire) begin
            r_pc_mem[r_tail] <= r_fetch_pc;
        end
        if (w_rsp_fill && !i_redirect_valid) begin
            r_instr_mem[r_fill] <= i_imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with 1-cycle
// response latency, scoreboard of expected {pc, instr} deliveries, a vector
// table for the streaming/backpressure cases and short hand-written
// sequences for stall, redirect and asynchronous reset corner cases.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        dec_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req_valid (imem_req_valid),
        .o_imem_req_addr  (imem_req_addr),
        .i_imem_req_ready (imem_req_ready),
        .i_imem_rsp_valid (imem_rsp_valid),
        .i_imem_rsp_data  (imem_rsp_data),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_valid          (o_valid),
        .o_instr          (o_instr),
        .o_pc             (o_pc),
        .i_ready          (dec_ready)
    );

    typedef struct {
        bit          do_rst;
        bit          req_rdy;
        bit          rsp_en;
        bit          dec_rdy;
        bit          exp_req_valid;
        logic [31:0] exp_addr;
        bit          exp_o_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] pend_q [$];   // addresses accepted by memory, awaiting response
    logic [31:0] exp_q  [$];   // scoreboard: PCs expected at the decoder, in order
    int          n_cmp = 0;
    int          n_err = 0;
    int          deq_count = 0;

    logic        s_req_valid;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {~a[15:0], a[15:0] ^ 16'h5A5A};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, update models after posedge.
    task automatic cycle(input bit req_rdy, input bit rsp_en, input bit dec_rdy,
                         input bit redir, input logic [31:0] redir_pc);
        logic        fire;
        logic [31:0] exp_pc;
        @(negedge clk);
        imem_req_ready = req_rdy;
        dec_ready      = dec_rdy;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        if (rsp_en && pend_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(pend_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        s_req_valid = imem_req_valid;
        s_addr      = imem_req_addr;
        s_valid     = o_valid;
        s_pc        = o_pc;
        fire        = imem_req_valid && imem_req_ready;
        if (redir) begin
            chk("o_valid_during_redirect", {31'b0, o_valid}, 32'd0);
            chk("req_valid_during_redirect", {31'b0, imem_req_valid}, 32'd0);
        end
        if (o_valid && dec_ready) begin
            deq_count++;
            if (exp_q.size() == 0) begin
                chk("deq_unexpected_pc", o_pc, 32'hDEAD_DEAD);
            end else begin
                exp_pc = exp_q.pop_front();
                chk("deq_pc", o_pc, exp_pc);
                chk("deq_instr", o_instr, mem_data(exp_pc));
            end
        end
        @(posedge clk);
        if (fire) begin
            pend_q.push_back(s_addr);
            exp_q.push_back(s_addr);
        end
        if (redir) exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        #1;
        chk("rst_o_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        repeat (2) @(negedge clk);
        pend_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    // Let everything in flight reach the decoder without issuing new requests.
    task automatic drain();
        for (int i = 0; i < 40 && (exp_q.size() > 0 || pend_q.size() > 0); i++)
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic apply_vec(input int i);
        if (vecs[i].do_rst) do_reset();
        cycle(vecs[i].req_rdy, vecs[i].rsp_en, vecs[i].dec_rdy, 1'b0, 32'h0);
        chk($sformatf("v%0d_req_valid", i), {31'b0, s_req_valid}, {31'b0, vecs[i].exp_req_valid});
        if (vecs[i].exp_req_valid) chk($sformatf("v%0d_addr", i), s_addr, vecs[i].exp_addr);
        chk($sformatf("v%0d_o_valid", i), {31'b0, s_valid}, {31'b0, vecs[i].exp_o_valid});
        if (vecs[i].exp_o_valid) chk($sformatf("v%0d_o_pc", i), s_pc, vecs[i].exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        // streaming: all ready, 1-cycle memory
        vecs[0]  = '{1, 1, 1, 1, 1, 32'h0,  0, 32'h0};
        vecs[1]  = '{0, 1, 1, 1, 1, 32'h4,  0, 32'h0};
        vecs[2]  = '{0, 1, 1, 1, 1, 32'h8,  1, 32'h0};
        vecs[3]  = '{0, 1, 1, 1, 1, 32'hC,  1, 32'h4};
        // decoder stalled: queue fills to DEPTH, then one dequeue frees a slot
        vecs[4]  = '{1, 1, 1, 0, 1, 32'h0,  0, 32'h0};
        vecs[5]  = '{0, 1, 1, 0, 1, 32'h4,  0, 32'h0};
        vecs[6]  = '{0, 1, 1, 0, 1, 32'h8,  1, 32'h0};
        vecs[7]  = '{0, 1, 1, 0, 1, 32'hC,  1, 32'h0};
        vecs[8]  = '{0, 1, 1, 0, 0, 32'h0,  1, 32'h0};
        vecs[9]  = '{0, 1, 1, 0, 0, 32'h0,  1, 32'h0};
        vecs[10] = '{0, 1, 1, 1, 0, 32'h0,  1, 32'h0};
        vecs[11] = '{0, 1, 1, 0, 1, 32'h10, 1, 32'h4};

        for (int i = 0; i < 4; i++) apply_vec(i);
        // steady state must deliver one instruction per cycle
        d0 = deq_count;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("stream_throughput", deq_count - d0, 32'd10);
        drain();

        for (int i = 4; i < 12; i++) apply_vec(i);

        // asynchronous reset with a full queue, mid clock-high phase
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_o_valid", {31'b0, o_valid}, 32'd0);
        chk("async_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        imem_req_ready = 1'b0;
        dec_ready      = 1'b0;
        imem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        pend_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("post_rst_req_valid", {31'b0, s_req_valid}, 32'd1);
        chk("post_rst_addr", s_addr, 32'h0);
        drain();

        // memory not ready for 3 cycles: address and valid held
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            chk($sformatf("stall%0d_req_valid", i), {31'b0, s_req_valid}, 32'd1);
            chk($sformatf("stall%0d_addr", i), s_addr, 32'h0);
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_fire_addr", s_addr, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_next_addr", s_addr, 32'h4);
        drain();

        // two outstanding, back-to-back redirects, last (0x103) wins
        do_reset();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h50);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h103);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_req_valid", {31'b0, s_req_valid}, 32'd1);
        chk("redir_addr", s_addr, 32'h100);
        drain();

        // redirect coinciding with a response and a ready decoder, one other outstanding
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir2_o_valid_next", {31'b0, s_valid}, 32'd0);
        chk("redir2_addr", s_addr, 32'h200);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir2_o_valid", {31'b0, s_valid}, 32'd1);
        chk("redir2_o_pc", s_pc, 32'h200);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
